lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_lane.sv | 62 ++++++
 rtl/lsu.sv | 136 +++++++++++++
 tb/tb_lsu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types: controller state encoding, MemOP codes and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [2:0] MOP_B    = 3'b000;
  localparam logic [2:0] MOP_H    = 3'b001;
  localparam logic [2:0] MOP_W    = 3'b010;
  localparam logic [2:0] MOP_BU   = 3'b100;
  localparam logic [2:0] MOP_HU   = 3'b101;
  localparam logic [2:0] MOP_NONE = 3'b111;

  // Halfwords need an even address, words a 4-byte-aligned one; bytes are always aligned.
  function automatic logic misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
    case (memop)
      MOP_H, MOP_HU: return addr_lo[0];
      MOP_W:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store mask/data replication and load extraction with sign/zero extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  memop,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = wdata;
    case (memop)
      MOP_B, MOP_BU: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      MOP_H, MOP_HU: begin
        wmask      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
      end
      MOP_W: begin
        wmask = 4'b1111;
      end
      default: wmask = 4'b0000;
    endcase
    // Loads never write, whatever the size
    if (!we) wmask = 4'b0000;
  end

  always_comb begin
    rd_byte = 8'h00;
    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    rdata_ext = 32'h0;
    case (memop)
      MOP_B:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
      MOP_BU:  rdata_ext = {24'h0, rd_byte};
      MOP_H:   rdata_ext = {{16{rd_half[15]}}, rd_half};
      MOP_HU:  rdata_ext = {16'h0, rd_half};
      MOP_W:   rdata_ext = rdata;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding bus transaction, IDLE->REQ->WAIT->RESP, with a WAIT timeout.
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses without a bus cycle.
module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_memop,
  input  logic             req_memwr,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [2:0]       memop_q;
  logic             memwr_q;
  logic [31:0]      rdata_ext;
  logic             reject;

  // Bus-side outputs come straight from the request latches, so they hold for the whole REQ phase
  lsu_lane u_lane (
    .addr_lo    (addr_q[1:0]),
    .memop      (memop_q),
    .we         (memwr_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wmask      (mem_wmask),
    .wdata_lane (mem_wdata),
    .rdata_ext  (rdata_ext)
  );

  assign mem_addr = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_we   = memwr_q;

`ifdef LSU_MISALIGN_CHECK_EN
  assign reject = misaligned(req_memop, req_addr[1:0]);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_req_valid <= 1'b0;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      memop_q       <= MOP_B;
      memwr_q       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            memop_q   <= req_memop;
            memwr_q   <= req_memwr;
            req_ready <= 1'b0;
            if (req_memop == MOP_NONE) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
            end else if (reject) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= memwr_q ? '0 : rdata_ext;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // TIMEOUT cycles spent in WAIT with no response from the bus
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: lane steering, latency, timeout, reset abort, misalign option.
`timescale 1ns/1ps
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_memop;
  logic        req_memwr;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_wmask;
  logic        o_we, o_err, o_mreq;
  int          o_lat;

  lsu #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_memop(req_memop), .req_memwr(req_memwr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, accept the bus request at once, answer in the first WAIT cycle.
  // o_lat is cycles from acceptance to rsp_valid (-1 if it never came).
  task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] mop,
                        input logic wr, input logic [31:0] rdin);
    int k;
    int phase;
    k = 0;
    while (!req_ready && k < 20) begin
      cyc();
      k++;
    end
    o_addr = '0; o_wdata = '0; o_wmask = '0; o_we = 1'b0; o_mreq = 1'b0;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_memop = mop; req_memwr = wr;
    cyc();
    req_valid = 1'b0;
    o_lat = 1;
    phase = 0;
    while (!rsp_valid && o_lat < 200) begin
      if (mem_req_valid) o_mreq = 1'b1;
      if (phase == 0 && mem_req_valid) begin
        o_addr = mem_addr; o_wdata = mem_wdata; o_wmask = mem_wmask; o_we = mem_we;
        mem_req_ready = 1'b1;
        phase = 1;
      end else if (phase == 1) begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = rdin;
        phase = 2;
      end else if (phase == 2) begin
        mem_rsp_valid = 1'b0;
      end
      cyc();
      o_lat++;
    end
    if (mem_req_valid) o_mreq = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    o_rdata = rsp_rdata;
    o_err = rsp_err;
    if (!rsp_valid) o_lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_memop = MOP_NONE; req_memwr = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_addr_wdata: got %h %h expected 0 0", mem_addr, mem_wdata); end
    checks++; if ({mem_we, mem_wmask} !== 5'b0) begin errors++; $display("FAIL reset_mem_we_wmask: got %b %b expected 0 0000", mem_we, mem_wmask); end
    checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL reset_rsp: got err %b rdata %h expected 0 0", rsp_err, rsp_rdata); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_store_word();
    run_op(32'h8000_0004, 32'hDEAD_BEEF, MOP_W, 1'b1, 32'h0);
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", o_lat); end
    checks++; if (o_addr !== 32'h8000_0004) begin errors++; $display("FAIL sw_addr: got %h expected 80000004", o_addr); end
    checks++; if (o_wmask !== 4'b1111) begin errors++; $display("FAIL sw_wmask: got %b expected 1111", o_wmask); end
    checks++; if (o_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", o_wdata); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", o_we); end
    checks++; if ({o_err, o_rdata} !== 33'h0) begin errors++; $display("FAIL sw_rsp: got err %b rdata %h expected 0 0", o_err, o_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_ready_in_resp: got %b expected 0", req_ready); end
    cyc();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL sw_after_resp: got valid/ready %b expected 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_load_byte();
    run_op(32'h8000_0003, 32'h0, MOP_B, 1'b0, 32'h80FF_1234);
    checks++; if (o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", o_rdata); end
    checks++; if ({o_addr, o_wmask, o_we} !== {32'h8000_0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL lb_bus: got addr %h wmask %b we %b expected 80000000 0000 0", o_addr, o_wmask, o_we); end
    cyc();
    checks++; if (rsp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_hold: got %h expected ffffff80", rsp_rdata); end
    run_op(32'h8000_0003, 32'h0, MOP_BU, 1'b0, 32'h80FF_1234);
    checks++; if (o_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000080", o_rdata); end
    run_op(32'h8000_0001, 32'h0, MOP_B, 1'b0, 32'h80FF_1234);
    checks++; if (o_rdata !== 32'h0000_0012) begin errors++; $display("FAIL lb1_rdata: got %h expected 00000012", o_rdata); end
  endtask

  task automatic test_load_half();
    run_op(32'h8000_0002, 32'h0, MOP_H, 1'b0, 32'hBEEF_0000);
    checks++; if (o_rdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_rdata: got %h expected ffffbeef", o_rdata); end
    run_op(32'h8000_0002, 32'h0, MOP_HU, 1'b0, 32'hBEEF_0000);
    checks++; if (o_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata: got %h expected 0000beef", o_rdata); end
    run_op(32'h8000_0000, 32'h0, MOP_H, 1'b0, 32'h8000_7FFF);
    checks++; if (o_rdata !== 32'h0000_7FFF) begin errors++; $display("FAIL lh0_rdata: got %h expected 00007fff", o_rdata); end
    run_op(32'h8000_0008, 32'h0, MOP_W, 1'b0, 32'h1234_5678);
    checks++; if (o_rdata !== 32'h1234_5678) begin errors++; $display("FAIL lw_rdata: got %h expected 12345678", o_rdata); end
  endtask

  task automatic test_store_lanes();
    run_op(32'h8000_0001, 32'h0000_00AB, MOP_B, 1'b1, 32'hFFFF_FFFF);
    checks++; if (o_wmask !== 4'b0010) begin errors++; $display("FAIL sb_wmask: got %b expected 0010", o_wmask); end
    checks++; if (o_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", o_wdata); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h expected 0", o_rdata); end
    run_op(32'h8000_0002, 32'h1234_CAFE, MOP_H, 1'b1, 32'h0);
    checks++; if ({o_wmask, o_wdata} !== {4'b1100, 32'hCAFE_CAFE}) begin errors++; $display("FAIL sh_lanes: got %b %h expected 1100 cafecafe", o_wmask, o_wdata); end
  endtask

  task automatic test_none();
    run_op(32'h8000_0004, 32'h0, MOP_NONE, 1'b0, 32'h0);
    checks++; if (o_lat !== 1) begin errors++; $display("FAIL none_latency: got %0d expected 1", o_lat); end
    checks++; if (o_mreq !== 1'b0) begin errors++; $display("FAIL none_no_bus: got %b expected 0", o_mreq); end
    checks++; if ({o_err, o_rdata} !== 33'h0) begin errors++; $display("FAIL none_rsp: got err %b rdata %h expected 0 0", o_err, o_rdata); end
  endtask

  task automatic test_timeout();
    int n;
    while (!req_ready) cyc();
    req_valid = 1'b1; req_addr = 32'h8000_0010; req_memop = MOP_W; req_memwr = 1'b0;
    cyc();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      cyc();
      n++;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL timeout_cycles: got %0d expected 64", n); end
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL timeout_rsp: got valid %b err %b rdata %h expected 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
    cyc();
    checks++; if ({req_ready, rsp_valid, rsp_err} !== 3'b101) begin errors++; $display("FAIL timeout_after: got ready/valid/err %b expected 101", {req_ready, rsp_valid, rsp_err}); end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    run_op(32'h8000_0003, 32'h0, MOP_BU, 1'b0, 32'h80FF_1234);
    cyc();
    req_valid = 1'b1; req_addr = 32'h8000_0000; req_memop = MOP_W; req_memwr = 1'b0;
    cyc();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, mem_req_valid, rsp_valid} !== 3'b100) begin errors++; $display("FAIL rstwait_immediate: got ready/mreq/valid %b expected 100", {req_ready, mem_req_valid, rsp_valid}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rstwait_rdata_cleared: got %h expected 0", rsp_rdata); end
    mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    cyc();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      cyc();
      mem_rsp_valid = 1'b0;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstwait_no_rsp: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
    run_op(32'h8000_0002, 32'h0, MOP_W, 1'b0, 32'h1122_3344);
    checks++; if ({o_err, o_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL misalign_lw_rsp: got err %b rdata %h expected 1 0", o_err, o_rdata); end
    checks++; if (o_mreq !== 1'b0) begin errors++; $display("FAIL misalign_lw_no_bus: got %b expected 0", o_mreq); end
    run_op(32'h8000_0001, 32'h5555, MOP_H, 1'b1, 32'h0);
    checks++; if ({o_err, o_mreq} !== 2'b10) begin errors++; $display("FAIL misalign_sh: got err/mreq %b expected 10", {o_err, o_mreq}); end
`else
    run_op(32'h8000_0002, 32'h0, MOP_W, 1'b0, 32'h1122_3344);
    checks++; if ({o_err, o_rdata, o_addr} !== {1'b0, 32'h1122_3344, 32'h8000_0000}) begin errors++; $display("FAIL misalign_lw: got err %b rdata %h addr %h expected 0 11223344 80000000", o_err, o_rdata, o_addr); end
    run_op(32'h8000_0001, 32'h0, MOP_H, 1'b0, 32'h1122_8344);
    checks++; if ({o_err, o_rdata} !== {1'b0, 32'hFFFF_8344}) begin errors++; $display("FAIL misalign_lh: got err %b rdata %h expected 0 ffff8344", o_err, o_rdata); end
`endif
  endtask

  task automatic test_back_to_back();
    run_op(32'h8000_0000, 32'h0, MOP_BU, 1'b0, 32'h0000_00C3);
    checks++; if (o_rdata !== 32'h0000_00C3) begin errors++; $display("FAIL b2b_first: got %h expected 000000c3", o_rdata); end
    cyc();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", req_ready); end
    run_op(32'h8000_0003, 32'h0000_0077, MOP_B, 1'b1, 32'h0);
    checks++; if ({o_lat, o_wmask, o_wdata} !== {32'd3, 4'b1000, 32'h7777_7777}) begin errors++; $display("FAIL b2b_second: got lat %0d wmask %b wdata %h expected 3 1000 77777777", o_lat, o_wmask, o_wdata); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_store_lanes();
    test_none();
    test_timeout();
    test_reset_in_wait();
    test_misalign();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
